// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  clkdiv_pkg : shared divisor type, limits and clamp helper for the divider
//  Rev 1.0
// ============================================================================
package clkdiv_pkg;

  localparam int DIV_W       = 32;
  localparam int MIN_DIV     = 2;
  localparam int DEFAULT_DIV = 100;

  typedef logic [DIV_W-1:0] div_t;

  // 0 and 1 cannot form a high and a low phase, so they are raised to MIN_DIV
  function automatic div_t clamp_div(input div_t d);
    return (d < div_t'(MIN_DIV)) ? div_t'(MIN_DIV) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_divider_multi_if.sv
`default_nettype none
// ============================================================================
//  clock_divider_multi_if : enable/divisor/load bus and divided outputs
//  Rev 1.0  (o_tick present only with CLKDIV_TICK_EN)
// ============================================================================
interface clock_divider_multi_if #(
  parameter int CH = 4,
  parameter int W  = 32
);
  logic [CH-1:0]   i_en;
  logic [CH*W-1:0] i_div;
  logic [CH-1:0]   i_load;
  logic [CH-1:0]   o_clk;
`ifdef CLKDIV_TICK_EN
  logic [CH-1:0]   o_tick;

  modport master (output i_en, i_div, i_load, input o_clk, o_tick);
  modport slave  (input i_en, i_div, i_load, output o_clk, o_tick);
`else
  modport master (output i_en, i_div, i_load, input o_clk);
  modport slave  (input i_en, i_div, i_load, output o_clk);
`endif
endinterface
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
//  clkdiv_channel : one divider channel with active/pending divisor
//  Rev 1.0  (W must not exceed clkdiv_pkg::DIV_W)
// ============================================================================
module clkdiv_channel #(
  parameter int W           = 32,
  parameter int DEFAULT_DIV = 100
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  input  wire logic         i_en,
  input  wire logic [W-1:0] i_div,
  input  wire logic         i_load,
`ifdef CLKDIV_TICK_EN
  output logic              o_tick,
`endif
  output logic              o_clk
);
  import clkdiv_pkg::*;

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_div;
  logic [W-1:0] r_pend;
  logic         r_pend_v;
  logic         r_clk;

  logic [W-1:0] w_load_div;
  logic [W:0]   w_hi;
  logic         w_wrap;
  logic         w_apply;
  logic [W-1:0] w_apply_div;

  assign w_load_div = W'(clamp_div(div_t'(i_div)));
  assign w_hi       = ({1'b0, r_div} + (W+1)'(1)) >> 1;
  assign w_wrap     = (r_cnt == r_div - W'(1));

  // A load arriving on the wrap edge bypasses the pending register
  assign w_apply     = (r_pend_v | i_load) & (~i_en | w_wrap);
  assign w_apply_div = i_load ? w_load_div : r_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_div    <= W'(DEFAULT_DIV);
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_clk    <= 1'b0;
    end else begin
      r_cnt <= (i_en && !w_wrap) ? r_cnt + W'(1) : '0;
      r_clk <= i_en & ({1'b0, r_cnt} < w_hi);
      if (w_apply) begin
        r_div    <= w_apply_div;
        r_pend_v <= 1'b0;
      end else if (i_load) begin
        r_pend   <= w_load_div;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign o_clk = r_clk;

`ifdef CLKDIV_TICK_EN
  logic r_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_tick <= 1'b0;
    else       r_tick <= i_en & w_wrap;
  end

  assign o_tick = r_tick;
`endif

endmodule
`default_nettype wire

// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
//  clock_divider_multi : CH independent programmable ~50% duty clock dividers
//  Rev 1.0  (define CLKDIV_TICK_EN for the per-period o_tick strobe)
// ============================================================================
module clock_divider_multi #(
  parameter int CH          = 4,
  parameter int W           = 32,
  parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
  input wire logic              i_clk,
  input wire logic              i_rst,
  clock_divider_multi_if.slave  bus
);
  import clkdiv_pkg::*;

  wire [CH-1:0] w_clk;
`ifdef CLKDIV_TICK_EN
  wire [CH-1:0] w_tick;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    clkdiv_channel #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (bus.i_en[c]),
      .i_div  (bus.i_div[c*W +: W]),
      .i_load (bus.i_load[c]),
`ifdef CLKDIV_TICK_EN
      .o_tick (w_tick[c]),
`endif
      .o_clk  (w_clk[c])
    );
  end

  assign bus.o_clk = w_clk;
`ifdef CLKDIV_TICK_EN
  assign bus.o_tick = w_tick;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
//  tb_clock_divider_multi : directed self-checking bench for the divider
//  Rev 1.0
// ============================================================================
module tb_clock_divider_multi;

  localparam int CH = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clock_divider_multi_if #(.CH(CH), .W(W)) bus ();

  clock_divider_multi #(.CH(CH), .W(W), .DEFAULT_DIV(100)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    bus.i_en   = '0;
    bus.i_load = '0;
    bus.i_div  = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic exp;
    rst        = 1'b1;
    bus.i_en   = '1;
    bus.i_load = '1;
    bus.i_div  = {CH{32'd5}};
    step();
    checks++;
    if (bus.o_clk !== 4'b0000) begin
      errors++;
      $display("FAIL reset_o_clk got %b want 0000", bus.o_clk);
    end
`ifdef CLKDIV_TICK_EN
    checks++;
    if (bus.o_tick !== 4'b0000) begin
      errors++;
      $display("FAIL reset_o_tick got %b want 0000", bus.o_tick);
    end
`endif
    // Load issued alongside reset must be discarded: default 100 still active
    rst        = 1'b0;
    bus.i_load = '0;
    bus.i_en   = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = ((k - 1) % 100) < 50;
      checks++;
      if (bus.o_clk[0] !== exp) begin
        errors++;
        $display("FAIL reset_wins k=%0d got %b want %b", k, bus.o_clk[0], exp);
      end
    end
  endtask

  task automatic test_default_period;
    logic exp;
    do_reset();
    bus.i_en[0] = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step();
      exp = ((k - 1) % 100) < 50;
      checks++;
      if (bus.o_clk[0] !== exp) begin
        errors++;
        $display("FAIL default_div100 k=%0d got %b want %b", k, bus.o_clk[0], exp);
      end
    end
  endtask

  task automatic test_load_mid_period;
    logic exp;
    do_reset();
    bus.i_en[1]       = 1'b1;
    bus.i_div[W +: W] = 32'd7;
    for (int k = 1; k <= 100; k++) begin
      bus.i_load[1] = (k == 11);
      step();
      exp = ((k - 1) % 100) < 50;
      checks++;
      if (bus.o_clk[1] !== exp) begin
        errors++;
        $display("FAIL load7_old_period k=%0d got %b want %b", k, bus.o_clk[1], exp);
      end
    end
    for (int j = 1; j <= 28; j++) begin
      step();
      exp = ((j - 1) % 7) < 4;
      checks++;
      if (bus.o_clk[1] !== exp) begin
        errors++;
        $display("FAIL load7_new_period j=%0d got %b want %b", j, bus.o_clk[1], exp);
      end
    end
  endtask

  task automatic test_clamp;
    logic exp;
    for (int v = 0; v <= 1; v++) begin
      do_reset();
      bus.i_div[2*W +: W] = 32'(v);
      bus.i_load[2]       = 1'b1;
      step();
      bus.i_load[2] = 1'b0;
      step();
      bus.i_en[2] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        step();
        exp = ((k - 1) % 2) == 0;
        checks++;
        if (bus.o_clk[2] !== exp) begin
          errors++;
          $display("FAIL clamp_div%0d k=%0d got %b want %b", v, k, bus.o_clk[2], exp);
        end
      end
    end
  endtask

  task automatic test_disable;
    logic exp;
    do_reset();
    bus.i_en[0] = 1'b1;
    for (int k = 1; k <= 20; k++) step();
    bus.i_en[0] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (bus.o_clk[0] !== 1'b0) begin
        errors++;
        $display("FAIL disable k=%0d got %b want 0", k, bus.o_clk[0]);
      end
    end
    bus.i_en[0] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      exp = ((k - 1) % 100) < 50;
      checks++;
      if (bus.o_clk[0] !== exp) begin
        errors++;
        $display("FAIL reenable k=%0d got %b want %b", k, bus.o_clk[0], exp);
      end
    end
  endtask

  task automatic test_reset_mid_period;
    logic exp;
    do_reset();
    bus.i_en[2] = 1'b1;
    bus.i_div[2*W +: W] = 32'd7;
    for (int k = 1; k <= 30; k++) begin
      bus.i_load[2] = (k == 30);
      step();
    end
    bus.i_load[2] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.o_clk !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_o_clk got %b want 0000", bus.o_clk);
    end
    for (int k = 1; k <= 110; k++) begin
      step();
      exp = ((k - 1) % 100) < 50;
      checks++;
      if (bus.o_clk[2] !== exp) begin
        errors++;
        $display("FAIL midreset_pend_dropped k=%0d got %b want %b", k, bus.o_clk[2], exp);
      end
    end
  endtask

  task automatic test_load_at_wrap;
    logic exp;
    do_reset();
    bus.i_en[0]       = 1'b1;
    bus.i_div[0 +: W] = 32'd4;
    for (int k = 1; k <= 100; k++) begin
      bus.i_load[0] = (k == 100);
      step();
      exp = ((k - 1) % 100) < 50;
      checks++;
      if (bus.o_clk[0] !== exp) begin
        errors++;
        $display("FAIL wrapload_old k=%0d got %b want %b", k, bus.o_clk[0], exp);
      end
    end
    bus.i_load[0] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      exp = ((j - 1) % 4) < 2;
      checks++;
      if (bus.o_clk[0] !== exp) begin
        errors++;
        $display("FAIL wrapload_new j=%0d got %b want %b", j, bus.o_clk[0], exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic exp;
    do_reset();
    bus.i_en[1] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      bus.i_load[1]     = (k == 6) || (k == 7);
      bus.i_div[W +: W] = (k == 6) ? 32'd9 : 32'd3;
      step();
      checks++;
      if (bus.o_clk[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ch0_idle k=%0d got %b want 0", k, bus.o_clk[0]);
      end
    end
    bus.i_load[1] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      exp = ((j - 1) % 3) < 2;
      checks++;
      if (bus.o_clk[1] !== exp) begin
        errors++;
        $display("FAIL b2b_last_wins j=%0d got %b want %b", j, bus.o_clk[1], exp);
      end
    end
  endtask

`ifdef CLKDIV_TICK_EN
  task automatic test_tick;
    logic exp_t;
    logic exp_c;
    do_reset();
    bus.i_div[3*W +: W] = 32'd5;
    bus.i_load[3]       = 1'b1;
    step();
    bus.i_load[3] = 1'b0;
    step();
    bus.i_en[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_t = ((k - 1) % 5) == 4;
      exp_c = ((k - 1) % 5) < 3;
      checks++;
      if (bus.o_tick[3] !== exp_t || bus.o_clk[3] !== exp_c) begin
        errors++;
        $display("FAIL tick_div5 k=%0d got tick=%b clk=%b want tick=%b clk=%b",
                 k, bus.o_tick[3], bus.o_clk[3], exp_t, exp_c);
      end
    end
  endtask
`endif

  initial begin
    bus.i_en   = '0;
    bus.i_load = '0;
    bus.i_div  = '0;
    test_reset();
    test_default_period();
    test_load_mid_period();
    test_clamp();
    test_disable();
    test_reset_mid_period();
    test_load_at_wrap();
    test_back_to_back();
`ifdef CLKDIV_TICK_EN
    test_tick();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
